// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, IF/ID register, one-entry skid, redirect/drop handling
// Optional bubble counter output enabled by defining FETCH_BUBBLE_COUNTER_EN.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallInput,
   input  logic        jumpInput,
   input  logic [31:0] pcJumpInput,
   input  logic        branchTakenInput,
   input  logic [31:0] pcBranchInput,
   output logic        imemReqOutput,
   output logic [31:0] imemAddrOutput,
   input  logic        imemReadyInput,
   input  logic [31:0] imemDataInput,
   output logic [31:0] instructionOutput,
   output logic [31:0] pc4Output,
   output logic        validOutput
`ifdef FETCH_BUBBLE_COUNTER_EN
   ,
   output logic [31:0] bubbleCountOutput
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HELD, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect = jumpInput | branchTakenInput;
   assign target   = branchTakenInput ? pcBranchInput : pcJumpInput;
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      drop_addr_d    = drop_addr_q;
      skid_d         = skid_q;
      instr_d        = instr_q;
      pc4_d          = pc4_q;
      valid_d        = valid_q;
      imemReqOutput  = 1'b0;
      imemAddrOutput = pc_q;

      // Decode drains IF/ID whenever it is not stalled; a refill below replaces the bubble.
      if (!stallInput) begin
         instr_d = NOP_WORD;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            imemReqOutput = 1'b1;
            if (redirect) begin
               state_d     = imemReadyInput ? FETCH : DROP;
               drop_addr_d = pc_q;
            end else if (imemReadyInput) begin
               if (stallInput) begin
                  skid_d  = imemDataInput;
                  state_d = HELD;
               end else begin
                  instr_d = imemDataInput;
                  pc4_d   = pc_plus4;
                  valid_d = 1'b1;
                  pc_d    = pc_plus4;
               end
            end
         end
         HELD: begin
            if (redirect) begin
               state_d = FETCH;
            end else if (!stallInput) begin
               instr_d = skid_q;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
               pc_d    = pc_plus4;
               state_d = FETCH;
            end
         end
         DROP: begin
            imemReqOutput  = 1'b1;
            imemAddrOutput = drop_addr_q;
            if (!redirect && imemReadyInput) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase

      // Redirect wins over stall and over any data arriving this cycle.
      if (redirect) begin
         pc_d    = target;
         instr_d = NOP_WORD;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
         skid_d  = 32'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         drop_addr_q <= 32'd0;
         skid_q      <= 32'd0;
         instr_q     <= NOP_WORD;
         pc4_q       <= 32'd0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         skid_q      <= skid_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
      end
   end

   assign instructionOutput = instr_q;
   assign pc4Output         = pc4_q;
   assign validOutput       = valid_q;

`ifdef FETCH_BUBBLE_COUNTER_EN
   logic [31:0] bubble_q, bubble_d;

   always_comb begin
      bubble_d = bubble_q;
      if (!valid_q && !stallInput) bubble_d = bubble_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bubble_q <= 32'd0;
      else       bubble_q <= bubble_d;
   end

   assign bubbleCountOutput = bubble_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized checks of instruction_fetch against an instruction-stream model
module tb_instruction_fetch;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stallInput = 1'b0;
   logic        jumpInput = 1'b0;
   logic        branchTakenInput = 1'b0;
   logic        imemReadyInput = 1'b0;
   logic [31:0] pcJumpInput = 32'd0;
   logic [31:0] pcBranchInput = 32'd0;
   logic [31:0] imemDataInput = 32'd0;
   logic        imemReqOutput;
   logic        validOutput;
   logic [31:0] imemAddrOutput;
   logic [31:0] instructionOutput;
   logic [31:0] pc4Output;
`ifdef FETCH_BUBBLE_COUNTER_EN
   logic [31:0] bubbleCountOutput;
   logic [31:0] bubble_exp = 32'd0;
`endif

   int          checks = 0;
   int          errors = 0;
   int          mem_lat = 0;
   int          mem_wait = 0;
   int          consumed = 0;
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] scr = 32'd0;

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
      .clk(clk),
      .reset(reset),
      .stallInput(stallInput),
      .jumpInput(jumpInput),
      .pcJumpInput(pcJumpInput),
      .branchTakenInput(branchTakenInput),
      .pcBranchInput(pcBranchInput),
      .imemReqOutput(imemReqOutput),
      .imemAddrOutput(imemAddrOutput),
      .imemReadyInput(imemReadyInput),
      .imemDataInput(imemDataInput),
      .instructionOutput(instructionOutput),
      .pc4Output(pc4Output),
      .validOutput(validOutput)
`ifdef FETCH_BUBBLE_COUNTER_EN
      , .bubbleCountOutput(bubbleCountOutput)
`endif
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory returns addr ^ scr after mem_lat wait cycles of a steady request.
   task automatic drive_mem();
      imemReadyInput = imemReqOutput && (mem_wait >= mem_lat);
      imemDataInput  = imemReadyInput ? (imemAddrOutput ^ scr) : $urandom;
   endtask

   // One clock: the model tracks the address of the next instruction decode should see.
   task automatic tick();
      logic        was_req, was_rdy, redir, took, in_rst;
      logic [31:0] was_addr, tgt;
      was_req  = imemReqOutput;
      was_rdy  = imemReadyInput;
      was_addr = imemAddrOutput;
      in_rst   = reset;
      redir    = jumpInput | branchTakenInput;
      tgt      = branchTakenInput ? pcBranchInput : pcJumpInput;
      took     = validOutput && !stallInput && !redir;
`ifdef FETCH_BUBBLE_COUNTER_EN
      if (in_rst) bubble_exp = 32'd0;
      else if (!validOutput && !stallInput) bubble_exp = bubble_exp + 32'd1;
`endif
      @(posedge clk);
      #1;
      if (in_rst) begin
         exp_pc = RST_PC;
         check_value("rst_req", imemReqOutput, 1'b0);
         check_value("rst_valid", validOutput, 1'b0);
         check_value("rst_instr", instructionOutput, NOP);
         check_value("rst_pc4", pc4Output, 32'd0);
      end else begin
         if (redir) begin
            exp_pc = tgt;
            check_value("flush_valid", validOutput, 1'b0);
            check_value("flush_instr", instructionOutput, NOP);
            check_value("flush_pc4", pc4Output, 32'd0);
         end else if (took) begin
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (was_req && !was_rdy) begin
            check_value("hold_req", imemReqOutput, 1'b1);
            check_value("hold_addr", imemAddrOutput, was_addr);
         end
      end
      if (validOutput) begin
         check_value("stream_pc4", pc4Output, exp_pc + 32'd4);
         check_value("stream_instr", instructionOutput, exp_pc ^ scr);
      end
`ifdef FETCH_BUBBLE_COUNTER_EN
      check_value("bubble_count", bubbleCountOutput, bubble_exp);
`endif
      mem_wait = (was_req && !was_rdy && !in_rst) ? mem_wait + 1 : 0;
      drive_mem();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stallInput = 1'b0;
      jumpInput = 1'b0;
      branchTakenInput = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!validOutput && n < budget) begin
         check_value({tag, "_early"}, validOutput, 1'b0);
         tick();
         n++;
      end
      check_value({tag, "_timeout"}, validOutput, 1'b1);
   endtask

   initial begin
      // zero-wait stream from reset
      mem_lat = 0;
      do_reset();
      tick();
      check_value("first_req", imemReqOutput, 1'b1);
      check_value("first_addr", imemAddrOutput, RST_PC);
      check_value("first_valid", validOutput, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_value("seq_valid", validOutput, 1'b1);
         check_value("seq_instr", instructionOutput, 32'(4 * i));
         check_value("seq_pc4", pc4Output, 32'(4 * i + 4));
      end

      // stall for three cycles while IF/ID holds pc4=8
      do_reset();
      repeat (3) tick();
      check_value("pre_stall_pc4", pc4Output, 32'd8);
      stallInput = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_value("stall_pc4", pc4Output, 32'd8);
         check_value("stall_instr", instructionOutput, 32'd4);
         check_value("stall_req", imemReqOutput, 1'b0);
      end
      stallInput = 1'b0;
      tick();
      check_value("release_pc4", pc4Output, 32'd12);
      check_value("release_instr", instructionOutput, 32'd8);
      tick();
      check_value("after_release_pc4", pc4Output, 32'd16);

      // jump while a slow request is outstanding
      mem_lat = 3;
      do_reset();
      tick();
      tick();
      jumpInput = 1'b1;
      pcJumpInput = 32'h40;
      tick();
      jumpInput = 1'b0;
      check_value("drop_req", imemReqOutput, 1'b1);
      check_value("drop_addr", imemAddrOutput, 32'h0);
      tick();
      tick();
      check_value("post_drop_req", imemReqOutput, 1'b1);
      check_value("post_drop_addr", imemAddrOutput, 32'h40);
      check_value("post_drop_valid", validOutput, 1'b0);
      wait_valid("jump_target", 20);
      check_value("jump_instr", instructionOutput, 32'h40);
      check_value("jump_pc4", pc4Output, 32'h44);

      // branch and jump together under stall
      mem_lat = 0;
      do_reset();
      tick();
      tick();
      stallInput = 1'b1;
      jumpInput = 1'b1;
      pcJumpInput = 32'h100;
      branchTakenInput = 1'b1;
      pcBranchInput = 32'h200;
      tick();
      stallInput = 1'b0;
      jumpInput = 1'b0;
      branchTakenInput = 1'b0;
      check_value("prio_addr", imemAddrOutput, 32'h200);
      tick();
      check_value("prio_instr", instructionOutput, 32'h200);
      check_value("prio_pc4", pc4Output, 32'h204);

      // PC wraps at the top of the address space
      jumpInput = 1'b1;
      pcJumpInput = 32'hFFFF_FFFC;
      tick();
      jumpInput = 1'b0;
      tick();
      check_value("wrap_instr", instructionOutput, 32'hFFFF_FFFC);
      check_value("wrap_pc4", pc4Output, 32'h0);
      check_value("wrap_addr", imemAddrOutput, 32'h0);

      // reset abandons an outstanding request; a late ready is ignored
      mem_lat = 3;
      do_reset();
      tick();
      tick();
      reset = 1'b1;
      #1;
      check_value("async_rst_req", imemReqOutput, 1'b0);
      check_value("async_rst_valid", validOutput, 1'b0);
      check_value("async_rst_instr", instructionOutput, NOP);
      tick();
      reset = 1'b0;
      imemReadyInput = 1'b1;
      imemDataInput = 32'hDEAD_BEEF;
      tick();
      check_value("late_req", imemReqOutput, 1'b1);
      check_value("late_addr", imemAddrOutput, RST_PC);
      tick();
      check_value("late_valid", validOutput, 1'b0);
      wait_valid("late_first", 20);
      check_value("late_instr", instructionOutput, RST_PC);

      // randomized traffic
      scr = $urandom;
      mem_lat = 0;
      do_reset();
      consumed = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) mem_lat = $urandom_range(0, 3);
         stallInput = ($urandom_range(0, 3) == 0);
         jumpInput = ($urandom_range(0, 15) == 0);
         branchTakenInput = ($urandom_range(0, 19) == 0);
         pcJumpInput = $urandom;
         pcBranchInput = $urandom;
         reset = ($urandom_range(0, 599) == 0);
         tick();
      end
      reset = 1'b0;
      stallInput = 1'b0;
      jumpInput = 1'b0;
      branchTakenInput = 1'b0;
      check_value("liveness", 32'(consumed > 300), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, the instruction word driven when the IF/ID register is empty or flushed.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stallInput  input  1  decode stage cannot accept a new instruction this cycle.
REQ-006 jumpInput  input  1  jump redirect from decode.
REQ-007 pcJumpInput  input  32  jump target address.
REQ-008 branchTakenInput  input  1  taken-branch redirect from a later stage.
REQ-009 pcBranchInput  input  32  branch target address.
REQ-010 imemReqOutput  output  1  instruction memory read request.
REQ-011 imemAddrOutput  output  32  word-aligned read address.
REQ-012 imemReadyInput  input  1  read data valid this cycle for the address being requested.
REQ-013 imemDataInput  input  32  read data.
REQ-014 instructionOutput  output  32  IF/ID instruction, consumed by decode as its instruction input.
REQ-015 pc4Output  output  32  IF/ID PC+4, consumed by decode as its PC+4 input.
REQ-016 validOutput  output  1  IF/ID holds a real instruction.

Function
REQ-017 SHALL implement the states IDLE, FETCH, HELD and DROP, with the PC held in a 32-bit register pcReg.
REQ-018 SHALL drive imemReqOutput high only in FETCH and DROP, with imemAddrOutput = pcReg in FETCH and the latched old address in DROP; the address SHALL stay stable while the request is unacknowledged.
REQ-019 IDLE SHALL go to FETCH on the first clock after reset deasserts.
REQ-020 FETCH with imemReadyInput=1 and stallInput=0 SHALL load the IF/ID register with {imemDataInput, pcReg+4, valid=1}, set pcReg to pcReg+4 and stay in FETCH, sustaining one instruction per cycle with a zero-wait memory.
REQ-021 FETCH with imemReadyInput=1 and stallInput=1 SHALL capture the data in a one-entry skid register, leave the IF/ID register unchanged and go to HELD.
REQ-022 HELD SHALL deassert the request; when stallInput=0 it SHALL move the skid register into IF/ID, set pcReg to pcReg+4 and return to FETCH.
REQ-023 While stallInput=1, the IF/ID register SHALL hold its contents unchanged.
REQ-024 On redirect, the target SHALL be pcBranchInput if branchTakenInput=1, otherwise pcJumpInput; branch has priority over jump.
REQ-025 A redirect SHALL:
- load the target into pcReg;
- clear validOutput and set instructionOutput to NOP_WORD and pc4Output to 0;
- discard the skid register and any data returned in the same cycle.
REQ-026 The redirect flush SHALL override stallInput.
REQ-027 After a redirect, the next state SHALL be:
- DROP if FETCH had an unacknowledged request (imemReadyInput=0);
- DROP if already in DROP (a newer redirect replaces the pending target);
- FETCH otherwise.
REQ-028 DROP SHALL keep requesting the old address until imemReadyInput=1, discard that data, then go to FETCH at the redirect target.
REQ-029 There SHALL be no branch delay slot: the instruction following a jump or branch SHALL never reach validOutput=1.
REQ-030 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
REQ-031 Targets SHALL be used as given, with no alignment check.

Reset
REQ-032 While reset=1, the block SHALL hold:
- state = IDLE and pcReg = RESET_PC;
- instructionOutput = NOP_WORD, pc4Output = 0, validOutput = 0;
- the skid register cleared and imemReqOutput = 0.
REQ-033 Reset asserted mid-request SHALL abandon the request; any later imemReadyInput is ignored until FETCH is re-entered.

Configuration
REQ-034 With macro FETCH_BUBBLE_COUNTER_EN defined, the block SHALL add output bubbleCountOutput (32 bits) that is reset to 0 and increments, wrapping, on every non-reset cycle in which validOutput=0 and stallInput=0.
REQ-035 Without FETCH_BUBBLE_COUNTER_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Zero-wait memory (ready every cycle) returning word=addr, RESET_PC=0 -> first request in the cycle after reset release; validOutput high one cycle later with instruction 0, pc4 4; then 4, 8, 12 on consecutive cycles.
REQ-037 Hold stallInput=1 for 3 cycles while IF/ID holds pc4=8 -> IF/ID stays at pc4=8 throughout; word 8 is held in skid; after release, pc4=12 appears one cycle later with no instruction lost or duplicated.
REQ-038 Memory with 3-cycle latency; jumpInput=1, pcJumpInput=0x40 in the second wait cycle -> DROP entered; the old data is discarded; next request address is 0x40; validOutput stays 0 until instruction 0x40 arrives.
REQ-039 jumpInput=1 (0x100) and branchTakenInput=1 (0x200) together with stallInput=1 -> IF/ID flushed to NOP, valid 0; next fetch address is 0x200.
REQ-040 pcReg=0xFFFF_FFFC fetched -> pc4Output=0 and the next request address is 0.
REQ-041 Reset pulsed while a request is outstanding -> all outputs return to reset values immediately; a late ready pulse is ignored; the first request after release is to RESET_PC.
